// File: rtl/tlb_pkg.sv
// Shared widths, FSM state and TLB entry layout for the TLB-lookup stage.
package tlb_pkg;

    localparam int VPN_W    = 8;
    localparam int PPN_W    = 8;
    localparam int OFFSET_W = 8;
    localparam int VADDR_W  = VPN_W + OFFSET_W;
    localparam int PADDR_W  = PPN_W + OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_REFILL
    } tlb_state_t;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_walk_if.sv
// Page-table-walk handshake between the TLB stage controller and the walker.
interface tlb_walk_if;

    logic                      walk_req;
    logic [tlb_pkg::VPN_W-1:0] walk_vpn;
    logic                      walk_ack;
    logic [tlb_pkg::PPN_W-1:0] walk_ppn;
    logic                      walk_fault;

    modport master (
        output walk_req,
        output walk_vpn,
        input  walk_ack,
        input  walk_ppn,
        input  walk_fault
    );

    modport slave (
        input  walk_req,
        input  walk_vpn,
        output walk_ack,
        output walk_ppn,
        output walk_fault
    );

endinterface

// File: rtl/tlb_cam.sv
// Fully associative TLB storage: lowest-index-wins lookup, round-robin refill
// port and a flush that clears every valid bit.
module tlb_cam
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             hit,
    output logic [PPN_W-1:0] hit_ppn,
    input  logic             wr_en,
    input  logic [VPN_W-1:0] wr_vpn,
    input  logic [PPN_W-1:0] wr_ppn
);

    localparam int RR_W = $clog2(ENTRIES);

    tlb_entry_t      entry_q [ENTRIES];
    logic [RR_W-1:0] rr_q;

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (entry_q[i].valid && (entry_q[i].vpn == lookup_vpn)) begin
                hit     = 1'b1;
                hit_ppn = entry_q[i].ppn;
            end
        end
    end

    // A flush on the refill edge suppresses the write, so the pointer holds too.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
            rr_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            entry_q[rr_q] <= '{valid: 1'b1, vpn: wr_vpn, ppn: wr_ppn};
            rr_q          <= rr_q + RR_W'(1);
        end
    end

endmodule

// File: rtl/tlb_stage_ctrl.sv
// TLB-lookup stage controller: translates on a hit with no added latency,
// otherwise stalls upstream, walks the page table and refills one entry.
module tlb_stage_ctrl
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [VADDR_W-1:0] req_vaddr,
    input  logic               flush,
    output logic               enable_tlblookup,
    output logic [PADDR_W-1:0] paddr,
    output logic               stall,
    output logic               fault,
    tlb_walk_if.master         walk
);

    tlb_state_t       state_q, state_d;
    logic             fault_q, fault_d;
    logic [VPN_W-1:0] walk_vpn_q;
    logic [PPN_W-1:0] walk_ppn_q;
    logic             latch_vpn;
    logic             refill_wr;
    logic             walk_req_c;
    logic             cam_hit;
    logic [PPN_W-1:0] cam_ppn;
    logic [VPN_W-1:0] req_vpn;

    assign req_vpn = req_vaddr[VADDR_W-1 -: VPN_W];

    tlb_cam #(
        .ENTRIES (ENTRIES)
    ) u_cam (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .lookup_vpn (req_vpn),
        .hit        (cam_hit),
        .hit_ppn    (cam_ppn),
        .wr_en      (refill_wr),
        .wr_vpn     (walk_vpn_q),
        .wr_ppn     (walk_ppn_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fault_q    <= 1'b0;
            walk_vpn_q <= '0;
            walk_ppn_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (latch_vpn) begin
                walk_vpn_q <= req_vpn;
            end
            if ((state_q == ST_WALK) && walk.walk_ack) begin
                walk_ppn_q <= walk.walk_ppn;
            end
        end
    end

    // The cycle after a faulting walk lets the op advance carrying the fault
    // instead of looking it up again.
    always_comb begin
        state_d          = state_q;
        fault_d          = 1'b0;
        latch_vpn        = 1'b0;
        refill_wr        = 1'b0;
        walk_req_c       = 1'b0;
        enable_tlblookup = 1'b0;
        stall            = 1'b0;
        fault            = 1'b0;
        paddr            = '0;
        if (reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fault_q) begin
                        enable_tlblookup = 1'b1;
                        fault            = 1'b1;
                    end else if (!req_valid) begin
                        enable_tlblookup = 1'b1;
                    end else if (cam_hit) begin
                        enable_tlblookup = 1'b1;
                        paddr            = {cam_ppn, req_vaddr[OFFSET_W-1:0]};
                    end else begin
                        stall     = 1'b1;
                        latch_vpn = 1'b1;
                        state_d   = ST_WALK;
                    end
                end
                ST_WALK: begin
                    walk_req_c = 1'b1;
                    stall      = 1'b1;
                    if (walk.walk_ack) begin
                        if (walk.walk_fault) begin
                            fault_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    stall     = 1'b1;
                    refill_wr = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign walk.walk_req = walk_req_c;
    assign walk.walk_vpn = walk_vpn_q;

endmodule

// File: tb/tb_tlb_stage_ctrl.sv
// Directed bench for tlb_stage_ctrl: a transaction-level TLB model predicts
// every cycle's outputs, plus literal checks on the documented scenarios.
module tb_tlb_stage_ctrl;

    localparam int ENTRIES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [15:0] req_vaddr;
    logic        flush;
    logic        enable_tlblookup;
    logic [15:0] paddr;
    logic        stall;
    logic        fault;

    tlb_walk_if wif ();

    tlb_stage_ctrl #(
        .ENTRIES (ENTRIES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_vaddr        (req_vaddr),
        .flush            (flush),
        .enable_tlblookup (enable_tlblookup),
        .paddr            (paddr),
        .stall            (stall),
        .fault            (fault),
        .walk             (wif.master)
    );

    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference TLB contents, replaced round-robin
    logic       m_valid [ENTRIES];
    logic [7:0] m_vpn   [ENTRIES];
    logic [7:0] m_ppn   [ENTRIES];
    int         m_rr;

    // Expected outputs for the current cycle
    logic        chk_on = 1'b0;
    logic        exp_en, exp_stall, exp_wreq, exp_fault;
    logic        exp_paddr_chk;
    logic [15:0] exp_paddr;
    logic [7:0]  exp_vpn;
    logic [7:0]  obs_vpn;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_lookup(input logic [7:0] vpn);
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i] && m_vpn[i] == vpn) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_vpn[i]   = '0;
            m_ppn[i]   = '0;
        end
        m_rr = 0;
    endtask

    task automatic m_flush();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_refill(input logic [7:0] vpn, input logic [7:0] ppn);
        m_valid[m_rr] = 1'b1;
        m_vpn[m_rr]   = vpn;
        m_ppn[m_rr]   = ppn;
        m_rr          = (m_rr + 1) % ENTRIES;
    endtask

    task automatic applyStimulus(input logic rv, input logic [15:0] va, input logic fl,
                                 input logic ack, input logic [7:0] wppn, input logic wf);
        @(posedge clk);
        #1;
        req_valid      = rv;
        req_vaddr      = va;
        flush          = fl;
        wif.walk_ack   = ack;
        wif.walk_ppn   = wppn;
        wif.walk_fault = wf;
    endtask

    task automatic set_exp(input logic en, input logic st, input logic wr, input logic fa);
        exp_en        = en;
        exp_stall     = st;
        exp_wreq      = wr;
        exp_fault     = fa;
        exp_paddr_chk = 1'b0;
    endtask

    // Per-cycle comparison against the model's prediction
    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("enable_tlblookup", 32'(enable_tlblookup), 32'(exp_en));
            checkOutput("stall", 32'(stall), 32'(exp_stall));
            checkOutput("walk_req", 32'(wif.walk_req), 32'(exp_wreq));
            checkOutput("fault", 32'(fault), 32'(exp_fault));
            if (exp_wreq) checkOutput("walk_vpn", 32'(wif.walk_vpn), 32'(exp_vpn));
            if (exp_paddr_chk) checkOutput("paddr", 32'(paddr), 32'(exp_paddr));
        end
    end

    // One upstream op from issue until it leaves the stage; the walker answers
    // after lat cycles of walk_req.
    task automatic translate(input logic [15:0] va, input int lat, input logic [7:0] ppn,
                             input logic wf, input logic flush_refill,
                             output int stall_cnt, output logic [15:0] pa_out);
        int   idx;
        bit   first = 1'b1;
        logic [7:0] vpn;
        vpn       = va[15:8];
        stall_cnt = 0;
        pa_out    = 'x;
        while (1) begin
            applyStimulus(1'b1, va, 1'b0, 1'b0, 8'h00, 1'b0);
            idx = m_lookup(vpn);
            if (idx >= 0) begin
                set_exp(1'b1, 1'b0, 1'b0, 1'b0);
                exp_paddr_chk = 1'b1;
                exp_paddr     = {m_ppn[idx], va[7:0]};
                @(negedge clk);
                if (stall === 1'b1) stall_cnt++;
                pa_out = paddr;
                break;
            end
            set_exp(1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (stall === 1'b1) stall_cnt++;
            for (int k = 1; k <= lat; k++) begin
                applyStimulus(1'b1, va, 1'b0, (k == lat), ppn, wf);
                set_exp(1'b0, 1'b1, 1'b1, 1'b0);
                exp_vpn = vpn;
                @(negedge clk);
                if (stall === 1'b1) stall_cnt++;
                obs_vpn = wif.walk_vpn;
            end
            if (wf) begin
                applyStimulus(1'b1, va, 1'b0, 1'b0, 8'h00, 1'b0);
                set_exp(1'b1, 1'b0, 1'b0, 1'b1);
                exp_paddr_chk = 1'b1;
                exp_paddr     = 16'h0000;
                @(negedge clk);
                pa_out = paddr;
                break;
            end
            applyStimulus(1'b1, va, first && flush_refill, 1'b0, 8'h00, 1'b0);
            set_exp(1'b0, 1'b1, 1'b0, 1'b0);
            if (first && flush_refill) m_flush();
            else m_refill(vpn, ppn);
            @(negedge clk);
            if (stall === 1'b1) stall_cnt++;
            first = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 16'h12AB, 1'b0, 1'b0, 8'h00, 1'b0);
            reset = 1'b0;
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
            exp_paddr_chk = 1'b1;
            exp_paddr     = 16'h0000;
            @(negedge clk);
        end
        m_reset();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          sc;
        logic [15:0] pa;
        reset          = 1'b0;
        req_valid      = 1'b0;
        req_vaddr      = '0;
        flush          = 1'b0;
        wif.walk_ack   = 1'b0;
        wif.walk_ppn   = '0;
        wif.walk_fault = 1'b0;
        m_reset();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        chk_on = 1'b1;

        $display("[TB] reset held with req_valid=1");
        reset_cycles(3);
        checkOutput("post_reset_enable", 32'(enable_tlblookup), 32'd1);

        $display("[TB] cold miss 0x12AB");
        translate(16'h12AB, 3, 8'h5C, 1'b0, 1'b0, sc, pa);
        checkOutput("cold_stall_cycles", 32'(sc), 32'd5);
        checkOutput("cold_walk_vpn", 32'(obs_vpn), 32'h12);
        checkOutput("cold_paddr", 32'(pa), 32'h5CAB);

        $display("[TB] hit 0x1234");
        translate(16'h1234, 1, 8'h00, 1'b0, 1'b0, sc, pa);
        checkOutput("hit_stall_cycles", 32'(sc), 32'd0);
        checkOutput("hit_paddr", 32'(pa), 32'h5C34);
        idle_cycle();

        $display("[TB] round-robin wrap");
        reset_cycles(2);
        for (int i = 1; i <= 5; i++) begin
            translate({8'(i), 8'(8'h10 + i)}, 1 + (i % 3), 8'(8'hA0 + i), 1'b0, 1'b0, sc, pa);
        end
        checkOutput("wrap_last_paddr", 32'(pa), 32'hA515);
        translate(16'h0240, 1, 8'h00, 1'b0, 1'b0, sc, pa);
        checkOutput("wrap_vpn02_hit_stalls", 32'(sc), 32'd0);
        checkOutput("wrap_vpn02_paddr", 32'(pa), 32'hA240);
        translate(16'h0141, 2, 8'hB1, 1'b0, 1'b0, sc, pa);
        checkOutput("wrap_vpn01_miss_stalls", 32'(sc), 32'd4);
        checkOutput("wrap_vpn01_paddr", 32'(pa), 32'hB141);

        $display("[TB] walk fault");
        translate(16'h7733, 2, 8'hEE, 1'b1, 1'b0, sc, pa);
        checkOutput("fault_paddr", 32'(pa), 32'h0000);
        idle_cycle();
        translate(16'h7734, 1, 8'h3D, 1'b0, 1'b0, sc, pa);
        checkOutput("fault_remiss_stalls", 32'(sc), 32'd3);
        checkOutput("fault_refill_paddr", 32'(pa), 32'h3D34);

        $display("[TB] flush during refill");
        translate(16'h4455, 2, 8'h66, 1'b0, 1'b1, sc, pa);
        checkOutput("flush_refill_stalls", 32'(sc), 32'd8);
        checkOutput("flush_refill_paddr", 32'(pa), 32'h6655);
        translate(16'h7701, 1, 8'h3E, 1'b0, 1'b0, sc, pa);
        checkOutput("flushed_entry_stalls", 32'(sc), 32'd3);

        $display("[TB] flush in idle");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        m_flush();
        @(negedge clk);
        translate(16'h4400, 1, 8'h67, 1'b0, 1'b0, sc, pa);
        checkOutput("post_flush_44_stalls", 32'(sc), 32'd3);
        translate(16'h7702, 1, 8'h3F, 1'b0, 1'b0, sc, pa);
        checkOutput("post_flush_77_stalls", 32'(sc), 32'd3);
        checkOutput("post_flush_77_paddr", 32'(pa), 32'h3F02);

        $display("[TB] reset during walk");
        applyStimulus(1'b1, 16'h99AA, 1'b0, 1'b0, 8'h00, 1'b0);
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 16'h99AA, 1'b0, 1'b0, 8'h00, 1'b0);
        set_exp(1'b0, 1'b1, 1'b1, 1'b0);
        exp_vpn = 8'h99;
        @(negedge clk);
        applyStimulus(1'b1, 16'h99AA, 1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        exp_paddr_chk = 1'b1;
        exp_paddr     = 16'h0000;
        @(negedge clk);
        m_reset();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 8'h11, 1'b0);
        reset = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        idle_cycle();
        translate(16'h99AA, 1, 8'h21, 1'b0, 1'b0, sc, pa);
        checkOutput("after_abort_stalls", 32'(sc), 32'd3);
        checkOutput("after_abort_paddr", 32'(pa), 32'h21AA);
        idle_cycle();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
